// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Purpose  : Shared widths and symmetric coefficient set for the fully
//             serial 16-tap linear-phase FIR filter.
//  Revision : 1.0  initial release
// ============================================================================
package fir_pkg;

    localparam int IW    = 12;            // input sample width
    localparam int CW    = 12;            // coefficient width
    localparam int OW    = 29;            // output / accumulator width
    localparam int TAPS  = 16;            // filter length
    localparam int PAIRS = TAPS / 2;      // symmetric tap pairs per frame
    localparam int PW    = IW + 1 + CW;   // pair-sum x coefficient width
    localparam int CNTW  = $clog2(PAIRS); // phase counter width
    localparam int IDXW  = $clog2(TAPS);  // delay-line index width

    // Half of the symmetric impulse response; tap k and tap TAPS-1-k share H[k]
    localparam logic signed [CW-1:0] H [0:PAIRS-1] = '{
        12'sd3, -12'sd7, -12'sd14, 12'sd12,
        12'sd58, 12'sd33, -12'sd121, 12'sd492
    };

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_pair_mac.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pair_mac
//  Purpose  : Combinational symmetric-pair multiply-accumulate:
//             acc_out = (clear ? 0 : acc_in) + (a + b) * h
//  Revision : 1.0  initial release
// ============================================================================
module fir_pair_mac
    import fir_pkg::*;
(
    input  logic signed [IW-1:0] a,
    input  logic signed [IW-1:0] b,
    input  logic signed [CW-1:0] h,
    input  logic signed [OW-1:0] acc_in,
    input  logic                 clear,
    output logic signed [OW-1:0] acc_out
);

    logic signed [IW:0]   w_sum;
    logic signed [PW-1:0] w_prod;
    logic signed [OW-1:0] w_prod_ext;

    // One extra bit on the pair sum keeps -2048 + -2048 exact
    assign w_sum = {a[IW-1], a} + {b[IW-1], b};

    // Both operands widened to the product width so the multiply is signed and exact
    assign w_prod = $signed({{(PW-IW-1){w_sum[IW]}}, w_sum})
                  * $signed({{(PW-CW){h[CW-1]}}, h});

    assign w_prod_ext = {{(OW-PW){w_prod[PW-1]}}, w_prod};

    // First pair of a frame starts a fresh sum, the rest accumulate
    assign acc_out = clear ? w_prod_ext : (acc_in + w_prod_ext);

endmodule : fir_pair_mac
`default_nettype wire

// File: rtl/fir_full_serial.sv
`default_nettype none
// ============================================================================
//  Module   : fir_full_serial
//  Purpose  : Fully serial 16-tap symmetric FIR. One sample per 8-clock
//             frame, one tap pair per clock through a single multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module fir_full_serial
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [IW-1:0] Xin,
    output logic signed [OW-1:0] Yout
);

    localparam logic [CNTW-1:0] c_last_phase = CNTW'(PAIRS - 1);

    logic [CNTW-1:0]      r_cnt;
    logic signed [IW-1:0] r_x [0:TAPS-1];
    logic signed [OW-1:0] r_acc;

    logic [IDXW-1:0]      w_idx_a;
    logic [IDXW-1:0]      w_idx_b;
    logic                 w_frame_end;
    logic                 w_frame_start;
    logic signed [OW-1:0] w_mac;

    assign w_idx_a       = IDXW'(r_cnt);
    assign w_idx_b       = IDXW'(TAPS - 1) - w_idx_a;
    assign w_frame_end   = (r_cnt == c_last_phase);
    assign w_frame_start = (r_cnt == '0);

    fir_pair_mac u_mac (
        .a       (r_x[w_idx_a]),
        .b       (r_x[w_idx_b]),
        .h       (H[r_cnt]),
        .acc_in  (r_acc),
        .clear   (w_frame_start),
        .acc_out (w_mac)
    );

    // Phase counter, running accumulator and frame output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
            Yout  <= '0;
        end else begin
            r_cnt <= r_cnt + CNTW'(1);
            r_acc <= w_mac;
            if (w_frame_end) begin
                Yout <= w_mac;
            end
        end
    end

    // Delay line shifts once per frame, on the same edge the result is latched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else if (w_frame_end) begin
            r_x[0] <= Xin;
            for (int k = 1; k < TAPS; k++) begin
                r_x[k] <= r_x[k-1];
            end
        end
    end

endmodule : fir_full_serial
`default_nettype wire

// File: tb/tb_fir_full_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_full_serial
//  Purpose  : Scoreboard bench for fir_full_serial. Stimulus pushes the
//             expected frame output; a monitor pops it at each frame edge
//             and checks the output stays put mid-frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_full_serial;

    logic               clk  = 1'b0;
    logic               rst  = 1'b1;
    logic signed [11:0] Xin  = '0;
    logic signed [28:0] Yout;

    fir_full_serial dut (
        .clk  (clk),
        .rst  (rst),
        .Xin  (Xin),
        .Yout (Yout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    exp;
        string name;
    } exp_t;

    // Full 16-tap impulse response written out directly
    localparam int TB_H [16] = '{3, -7, -14, 12, 58, 33, -121, 492,
                                 492, -121, 33, 58, 12, -14, -7, 3};

    localparam int TONE [24] = '{0, 812, 1490, 1903, 1977, 1705, 1152, 433,
                                 -310, -961, -1420, -1633, -1590, -1320, -880, -350,
                                 180, 640, 980, 1150, 1120, 900, 520, 40};

    exp_t sb[$];
    int   hist[16];
    int   total    = 0;
    int   bad      = 0;
    bit   running  = 1'b0;
    int   edge_n   = 0;
    int   last_exp = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Output due at the edge that captures the next sample: history before the shift
    function automatic int model();
        int y = 0;
        for (int k = 0; k < 16; k++) y += TB_H[k] * hist[k];
        return y;
    endfunction

    // One 8-clock frame; optional junk on Xin except across the capture edge
    task automatic send(input int v, input bit glitch, input bit use_const,
                        input int cval, input string name);
        exp_t e;
        e.exp  = use_const ? cval : model();
        e.name = name;
        sb.push_back(e);
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = v;
        for (int i = 0; i < 8; i++) begin
            Xin = (glitch && i != 7) ? 12'($urandom) : 12'(v);
            @(negedge clk);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst      = 1'b0;
        edge_n   = 0;
        last_exp = 0;
        running  = 1'b1;
    endtask

    // Monitor: pop at each frame edge, check hold in the middle of each frame
    always @(posedge clk) begin
        exp_t e;
        if (running) begin
            #1;
            if (running) begin
                edge_n++;
                if (edge_n % 8 == 0) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL scoreboard_empty: got output %0d with no expected entry", int'(Yout));
                    end else begin
                        e = sb.pop_front();
                        check(e.name, int'(Yout), e.exp);
                        last_exp = e.exp;
                    end
                end else if (edge_n % 8 == 4) begin
                    check("hold", int'(Yout), last_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) hist[k] = 0;

        repeat (3) @(negedge clk);
        check("reset_state", int'(Yout), 0);
        release_reset();

        // Positive unit impulse then flush to zero
        send(1, 1'b0, 1'b0, 0, "impulse_pos");
        for (int i = 0; i < 17; i++) send(0, 1'b0, 1'b0, 0, "impulse_pos");

        // Negative unit impulse
        send(-1, 1'b0, 1'b0, 0, "impulse_neg");
        for (int i = 0; i < 17; i++) send(0, 1'b0, 1'b0, 0, "impulse_neg");

        // DC extremes; once the line is full the output is a hand constant
        for (int i = 0; i < 20; i++)
            send(2047, 1'b0, (i >= 16), 1866864, (i >= 16) ? "dc_pos_settled" : "dc_pos_ramp");
        for (int i = 0; i < 20; i++)
            send(-2048, 1'b0, (i >= 16), -1867776, (i >= 16) ? "dc_neg_settled" : "dc_neg_ramp");

        // Mid-frame reset with full negative history
        Xin = 12'sd100;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_async", int'(Yout), 0);
        running = 1'b0;
        sb.delete();
        for (int k = 0; k < 16; k++) hist[k] = 0;
        repeat (3) @(negedge clk);
        release_reset();

        // Restart: first frame must still read zero, then a stepped ramp-up
        for (int i = 0; i < 4; i++) send(2047, 1'b0, 1'b0, 0, "post_reset");

        // Junk on Xin away from the capture edge must be ignored
        send(500, 1'b1, 1'b0, 0, "ignore");
        send(500, 1'b1, 1'b0, 0, "ignore");
        send(-300, 1'b1, 1'b0, 0, "ignore");
        send(-300, 1'b1, 1'b0, 0, "ignore");
        send(1000, 1'b1, 1'b0, 0, "ignore");
        send(-2048, 1'b1, 1'b0, 0, "ignore");
        send(2047, 1'b1, 1'b0, 0, "ignore");
        send(0, 1'b1, 1'b0, 0, "ignore");

        // Mixed tone segment
        for (int i = 0; i < 24; i++) send(TONE[i], 1'b0, 1'b0, 0, "tone");
        for (int i = 0; i < 16; i++) send(0, 1'b0, 1'b0, 0, "tone_tail");

        repeat (4) @(negedge clk);
        running = 1'b0;
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fir_full_serial
`default_nettype wire
